// File: rtl/ip_tile_host_bridge.sv
// Host register bridge feeding ip_tile CSR/data inputs and capturing its results.
// Optional IRQ output and IRQ_EN register under IP_TILE_HOST_BRIDGE_IRQ_EN.
module ip_tile_host_bridge #(
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int REG_WIDTH     = 32,
  parameter int ADDR_WIDTH    = 5
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [REG_WIDTH-1:0]     wdata,
  output logic                     gnt,
  output logic                     rvalid,
  output logic [REG_WIDTH-1:0]     rdata,
  output logic                     err,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  output logic                     csr_in_re,
  output logic [REG_WIDTH-1:0]     data_reg_a,
  output logic [REG_WIDTH-1:0]     data_reg_b,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic                     csr_out_we,
  input  logic [REG_WIDTH-1:0]     data_reg_c
`ifdef IP_TILE_HOST_BRIDGE_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int AW = ADDR_WIDTH - 2;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [CSR_IN_WIDTH-1:0]  csr_in_q, csr_in_d;
  logic [REG_WIDTH-1:0]     data_a_q, data_a_d;
  logic [REG_WIDTH-1:0]     data_b_q, data_b_d;
  logic [CSR_OUT_WIDTH-1:0] csr_out_q, csr_out_d;
  logic [REG_WIDTH-1:0]     data_c_q, data_c_d;
  logic                     done_q, done_d;
  logic                     ovr_q, ovr_d;
  logic                     busy_q, busy_d;
  logic                     re_q, re_d;
  logic [REG_WIDTH-1:0]     rdata_q, rdata_d;
  logic                     err_q, err_d;

  logic [AW-1:0]        sel;
  logic [REG_WIDTH-1:0] rd_val;
  logic                 mapped;
  logic                 ro;
  logic                 acc_err;
  logic                 wr_ok;
  logic                 status_rd;
  logic                 addr_unused;

  assign sel         = addr[ADDR_WIDTH-1:2];
  assign addr_unused = ^addr[1:0];

`ifdef IP_TILE_HOST_BRIDGE_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    rvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt = req;
        if (req) state_d = RESP;
      end
      RESP: begin
        rvalid  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    ro     = 1'b0;
    unique case (sel)
      AW'(0): rd_val = REG_WIDTH'(csr_in_q);
      AW'(1): rd_val = data_a_q;
      AW'(2): rd_val = data_b_q;
      AW'(3): begin
        rd_val = REG_WIDTH'(csr_out_q);
        ro     = 1'b1;
      end
      AW'(4): begin
        rd_val = data_c_q;
        ro     = 1'b1;
      end
      AW'(5): begin
        rd_val = REG_WIDTH'({busy_q, ovr_q, done_q});
        ro     = 1'b1;
      end
`ifdef IP_TILE_HOST_BRIDGE_IRQ_EN
      AW'(6): rd_val = REG_WIDTH'(irq_en_q);
`endif
      default: mapped = 1'b0;
    endcase
  end

  assign acc_err   = ~mapped | (we & ro);
  assign wr_ok     = gnt & we & ~acc_err;
  assign status_rd = gnt & ~we & (sel == AW'(5));

  always_comb begin
    csr_in_d  = csr_in_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    re_d      = 1'b0;
    if (wr_ok) begin
      unique case (sel)
        AW'(0): begin
          csr_in_d = wdata[CSR_IN_WIDTH-1:0];
          re_d     = 1'b1;
        end
        AW'(1): data_a_d = wdata;
        AW'(2): data_b_d = wdata;
        default: ;
      endcase
    end
    csr_out_d = csr_out_we ? csr_out : csr_out_q;
    data_c_d  = csr_out_we ? data_reg_c : data_c_q;
    // a capture in the same cycle as a STATUS read survives the clear
    done_d    = csr_out_we | (done_q & ~status_rd);
    ovr_d     = ~status_rd & (ovr_q | (csr_out_we & done_q));
    busy_d    = re_d | (busy_q & ~csr_out_we);
    rdata_d   = (gnt & ~we) ? rd_val : '0;
    err_d     = gnt & acc_err;
  end

`ifdef IP_TILE_HOST_BRIDGE_IRQ_EN
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_ok && sel == AW'(6)) irq_en_d = wdata[0];
    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      csr_in_q  <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      csr_out_q <= '0;
      data_c_q  <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
      re_q      <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      csr_in_q  <= csr_in_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      csr_out_q <= csr_out_d;
      data_c_q  <= data_c_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
      re_q      <= re_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign rdata      = rdata_q;
  assign err        = err_q;
  assign csr_in     = csr_in_q;
  assign csr_in_re  = re_q;
  assign data_reg_a = data_a_q;
  assign data_reg_b = data_b_q;

endmodule
